// File: rtl/long_fifo_stream_rd_pkg.sv
// Shared constants and helpers for the long-FIFO read-side stream stage.
package long_fifo_stream_rd_pkg;

  localparam logic [1:0] OCC_MAX = 2'd2;

  // Words owned by the stage: buffered entries plus the read still in flight.
  function automatic logic [1:0] occ_of(input logic [1:0] cnt, input logic inflight);
    return cnt + {1'b0, inflight};
  endfunction

endpackage

// File: rtl/long_fifo_stream_rd_sva.sv
// Protocol checker for the read-side stream stage (read issue, occupancy, stall stability).
module long_fifo_stream_rd_sva
  import long_fifo_stream_rd_pkg::*;
#(
  parameter int DSIZE = 10
) (
  input logic             clock,
  input logic             rst_n,
  input logic             fifo_empty,
  input logic             fifo_rd_en,
  input logic [1:0]       occ,
  input logic [1:0]       cnt,
  input logic             capture,
  input logic             pop,
  input logic             out_valid,
  input logic             out_ready,
  input logic [DSIZE-1:0] out_data,
  input logic             out_last
);

  a_no_rd_when_empty: assert property (@(posedge clock) disable iff (!rst_n)
    fifo_rd_en |-> !fifo_empty);

  a_occ_max: assert property (@(posedge clock) disable iff (!rst_n)
    occ <= OCC_MAX);

  a_no_overflow: assert property (@(posedge clock) disable iff (!rst_n)
    !(capture && (cnt == OCC_MAX) && !pop));

  a_stall_stable: assert property (@(posedge clock) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_last)));

endmodule

// File: rtl/stream_buf_2entry.sv
// Two-deep register FIFO with push/pop and an entry count; head is always presented.
module stream_buf_2entry
  import long_fifo_stream_rd_pkg::*;
#(
  parameter int DSIZE = 10
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [DSIZE-1:0] i_push_data,
  input  logic             i_pop,
  output logic [DSIZE-1:0] o_head,
  output logic [1:0]       o_cnt
);

  logic [DSIZE-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_cnt;
  logic             w_push;
  logic             w_pop;

  // A push into a full buffer is only accepted when the head leaves in the same cycle.
  assign w_pop  = i_pop && (r_cnt != 2'd0);
  assign w_push = i_push && ((r_cnt != OCC_MAX) || w_pop);

  // Storage, pointers and count.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_mem[0] <= {DSIZE{1'b0}};
      r_mem[1] <= {DSIZE{1'b0}};
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_head = r_mem[r_rd_ptr];
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/long_fifo_stream_rd.sv
// Read-side consumer of the long FIFO: issues reads against a 1-cycle dout latency
// and re-presents the words as a valid/ready stream with optional packet framing.
module long_fifo_stream_rd
  import long_fifo_stream_rd_pkg::*;
#(
  parameter  int DSIZE      = 10,
  parameter  int PKT_LEN    = 0,
  parameter  int RD_LATENCY = 1,
  localparam int CW         = ($clog2(PKT_LEN) > 1) ? $clog2(PKT_LEN) : 1
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [DSIZE-1:0] fifo_dout,
  output logic [DSIZE-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CW-1:0]    beat_cnt
);

  if (RD_LATENCY != 1) begin : g_bad_latency
    $error("long_fifo_stream_rd: only RD_LATENCY = 1 is supported");
  end

  logic             r_inflight;
  logic             r_rd_ok;
  logic [1:0]       w_cnt;
  logic [1:0]       w_occ;
  logic [DSIZE-1:0] w_head;
  logic             w_valid;
  logic             w_pop;
  logic             w_rd_en;

  // Reads are gated only by registered occupancy so out_ready never reaches fifo_rd_en;
  // r_rd_ok holds reads off for the first cycle after reset.
  assign w_occ   = occ_of(w_cnt, r_inflight);
  assign w_rd_en = r_rd_ok && !fifo_empty && (w_occ < OCC_MAX);
  assign w_valid = (w_cnt != 2'd0);
  assign w_pop   = w_valid && out_ready;

  // In-flight read tracking and post-reset read enable.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_rd_ok    <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      r_rd_ok    <= 1'b1;
    end
  end

  stream_buf_2entry #(.DSIZE(DSIZE)) u_buf (
    .clock       (clock),
    .rst_n       (rst_n),
    .i_push      (r_inflight),
    .i_push_data (fifo_dout),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_cnt       (w_cnt)
  );

  if (PKT_LEN > 1) begin : g_pkt
    localparam logic [CW-1:0] LAST_BEAT = CW'(PKT_LEN - 1);
    logic [CW-1:0] r_beat;

    // Beat index within the packet, advanced on every accepted beat.
    always_ff @(posedge clock) begin
      if (!rst_n) begin
        r_beat <= {CW{1'b0}};
      end else if (w_pop) begin
        r_beat <= (r_beat == LAST_BEAT) ? {CW{1'b0}} : r_beat + CW'(1);
      end else begin
        r_beat <= r_beat;
      end
    end

    assign beat_cnt = r_beat;
    assign out_last = w_valid && (r_beat == LAST_BEAT);
  end else if (PKT_LEN == 1) begin : g_single
    assign beat_cnt = {CW{1'b0}};
    assign out_last = w_valid;
  end else begin : g_none
    assign beat_cnt = {CW{1'b0}};
    assign out_last = 1'b0;
  end

  assign fifo_rd_en = w_rd_en;
  assign out_valid  = w_valid;
  assign out_data   = w_head;

  long_fifo_stream_rd_sva #(.DSIZE(DSIZE)) u_sva (
    .clock      (clock),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (w_rd_en),
    .occ        (w_occ),
    .cnt        (w_cnt),
    .capture    (r_inflight),
    .pop        (w_pop),
    .out_valid  (w_valid),
    .out_ready  (out_ready),
    .out_data   (w_head),
    .out_last   (out_last)
  );

endmodule

// File: tb/tb_long_fifo_stream_rd.sv
// Scoreboard bench: a behavioural 1-cycle-latency FIFO feeds the DUT, loaded words are queued
// as expected beats, and a negedge monitor checks every accepted beat and every stall cycle.
module tb_long_fifo_stream_rd;

  localparam int DSIZE = 10;
  localparam int PKT   = 4;

  logic             clock = 1'b0;
  logic             rst_n = 1'b0;
  logic             fifo_empty = 1'b1;
  logic             fifo_rd_en;
  logic [DSIZE-1:0] fifo_dout = '0;
  logic [DSIZE-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_last;
  logic [1:0]       beat_cnt;

  always #5 clock = ~clock;

  long_fifo_stream_rd #(.DSIZE(DSIZE), .PKT_LEN(PKT), .RD_LATENCY(1)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .beat_cnt   (beat_cnt)
  );

  typedef struct packed {
    logic [DSIZE-1:0] data;
    logic [1:0]       beat;
    logic             last;
  } exp_t;

  exp_t             exp_q[$];
  logic [DSIZE-1:0] fifo_q[$];
  int               n_vec = 0;
  int               n_miss = 0;
  int               n_pop = 0;
  int               rd_count = 0;
  int               exp_idx = 0;
  logic             rd_s;
  logic             valid_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: sample at negedge, then advance the FIFO model just after posedge.
  task automatic tick();
    @(negedge clock);
    rd_s    = fifo_rd_en;
    valid_s = out_valid;
    if (rst_n) check("rd_while_empty", {31'd0, (fifo_rd_en === 1'b1) && fifo_empty}, 32'd0);
    if (rd_s === 1'b1) rd_count++;
    @(posedge clock);
    #1;
    if (rd_s === 1'b1 && fifo_q.size() != 0) fifo_dout = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic load(input logic [DSIZE-1:0] w);
    exp_t e;
    e.data = w;
    e.beat = 2'(exp_idx % PKT);
    e.last = ((exp_idx % PKT) == (PKT - 1));
    fifo_q.push_back(w);
    exp_q.push_back(e);
    exp_idx++;
    fifo_empty = 1'b0;
  endtask

  // Reset with a word sitting in the FIFO so fifo_rd_en must be held low by reset itself.
  task automatic do_reset(input int ncyc);
    fifo_q.delete();
    fifo_q.push_back(10'h3FF);
    fifo_empty = 1'b0;
    rst_n = 1'b0;
    repeat (ncyc) tick();
    rst_n = 1'b1;
    check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_beat", {30'd0, beat_cnt}, 32'd0);
    fifo_q.delete();
    fifo_empty = 1'b1;
    exp_q.delete();
    exp_idx  = 0;
    rd_count = 0;
  endtask

  task automatic drain(input string name, input int maxc, input logic toggle);
    int c = 0;
    while ((exp_q.size() != 0 || out_valid !== 1'b0) && c < maxc) begin
      tick();
      if (toggle) out_ready = ~out_ready;
      c++;
    end
    check({name, "_drained"}, exp_q.size(), 32'd0);
    check({name, "_idle"}, {31'd0, out_valid}, 32'd0);
  endtask

  // Monitor: every accepted beat is popped from the scoreboard; stalls must hold the beat.
  initial begin
    logic             prev_stall = 1'b0;
    logic [DSIZE-1:0] prev_data = '0;
    logic             prev_last = 1'b0;
    exp_t             e;
    forever begin
      @(negedge clock);
      if (rst_n !== 1'b1) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", {31'd0, out_valid}, 32'd1);
          check("stall_data", {22'd0, out_data}, {22'd0, prev_data});
          check("stall_last", {31'd0, out_last}, {31'd0, prev_last});
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_beat: got %0h, expected no beat (t=%0t)", out_data, $time);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", {22'd0, out_data}, {22'd0, e.data});
            check("beat_cnt", {30'd0, beat_cnt}, {30'd0, e.beat});
            check("beat_last", {31'd0, out_last}, {31'd0, e.last});
          end
          n_pop++;
        end
        prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
        prev_data  = out_data;
        prev_last  = out_last;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_rd;
    int first_valid;
    int base;
    int c;

    @(posedge clock);
    #1;
    do_reset(2);

    // Preloaded 0x001..0x008, ready held high: read/valid latency and in-order delivery.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) load(10'(i));
    first_rd = -1;
    first_valid = -1;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (rd_s === 1'b1 && first_rd < 0) first_rd = k;
      if (valid_s === 1'b1 && first_valid < 0) first_valid = k;
      if (exp_q.size() == 0 && out_valid === 1'b0) break;
    end
    check("t1_first_rd_cycle", first_rd, 32'd1);
    check("t1_first_valid_cycle", first_valid, 32'd3);
    check("t1_rd_pulses", rd_count, 32'd8);
    check("t1_drained", exp_q.size(), 32'd0);
    check("t1_idle", {31'd0, out_valid}, 32'd0);

    // Same load, out_ready toggling every cycle.
    do_reset(2);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) load(10'(i));
    drain("t2", 80, 1'b1);
    check("t2_rd_pulses", rd_count, 32'd8);

    // Ten words through the packet counter: last on beats 4 and 8.
    do_reset(2);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) load(10'h011 + 10'(i));
    drain("t3", 80, 1'b0);

    // Long back-pressure: only two reads, then resume in order.
    do_reset(2);
    out_ready = 1'b0;
    for (int i = 1; i <= 16; i++) load(10'(i));
    repeat (20) tick();
    check("t4_rd_pulses_stalled", rd_count, 32'd2);
    check("t4_rd_en_low", {31'd0, fifo_rd_en}, 32'd0);
    check("t4_valid_held", {31'd0, out_valid}, 32'd1);
    check("t4_head", {22'd0, out_data}, 32'h001);
    out_ready = 1'b1;
    drain("t4", 120, 1'b0);
    check("t4_rd_pulses_total", rd_count, 32'd16);

    // Mid-packet reset with a full buffer, then fresh words must start at beat 0.
    do_reset(2);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) load(10'h041 + 10'(i));
    base = n_pop;
    c = 0;
    while (n_pop < base + 2 && c < 20) begin
      tick();
      c++;
    end
    out_ready = 1'b0;
    repeat (4) tick();
    check("t5_valid_before_rst", {31'd0, out_valid}, 32'd1);
    check("t5_beat_before_rst", {30'd0, beat_cnt}, 32'd2);
    do_reset(1);
    for (int i = 0; i < 3; i++) load(10'h0A1 + 10'(i));
    out_ready = 1'b1;
    drain("t5", 60, 1'b0);

    // Single word: empty drops for one cycle only.
    do_reset(2);
    out_ready = 1'b1;
    repeat (3) tick();
    check("t6_no_rd_idle", rd_count, 32'd0);
    load(10'h155);
    repeat (10) tick();
    check("t6_rd_pulses", rd_count, 32'd1);
    check("t6_drained", exp_q.size(), 32'd0);
    check("t6_idle", {31'd0, out_valid}, 32'd0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
